// File: rtl/pong_match_controller.sv
// Pong match sequencer: owns ball position and direction, paddle and wall
// reflection, scoring and the IDLE/SERVE/PLAY/OVER match state. The ball
// moves at most one step per frame strobe, so the painter never sees a
// half-updated position.
module pong_match_controller #(
    parameter int SCREEN_WIDTH             = 640,
    parameter int SCREEN_HEIGHT            = 480,
    parameter int BALL_SIZE                = 7,
    parameter int PADDLE_HEIGHT            = 100,
    parameter int PADDLE_WIDTH             = 10,
    parameter int PADDLE_HORIZONTAL_OFFSET = 20,
    parameter int BORDER_OFFSET            = 5,
    parameter int SERVE_DELAY_FRAMES       = 60,
    parameter int WIN_SCORE                = 7
) (
    input  logic       clock_25M,
    input  logic       reset,
    input  logic       frame,
    input  logic       start,
    input  logic [9:0] pad_left_position,
    input  logic [9:0] pad_right_position,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_visible,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] game_state,
    output logic       winner
);

    // Serve counter width; at least one bit even for a one-frame serve.
    localparam int CW = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    // Ball home position.
    localparam logic [9:0] CX = 10'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam logic [9:0] CY = 10'((SCREEN_HEIGHT - BALL_SIZE) / 2);

    // Geometry in 11 bits so that pad + PADDLE_HEIGHT cannot wrap.
    localparam logic [10:0] X_RIGHT_MISS = 11'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic [10:0] X_LEFT_HIT   = 11'(PADDLE_HORIZONTAL_OFFSET + PADDLE_WIDTH);
    localparam logic [10:0] X_RIGHT_HIT  = 11'(SCREEN_WIDTH - PADDLE_HORIZONTAL_OFFSET
                                               - PADDLE_WIDTH - BALL_SIZE);
    localparam logic [10:0] Y_TOP        = 11'(BORDER_OFFSET);
    localparam logic [10:0] Y_BOTTOM     = 11'(SCREEN_HEIGHT - BORDER_OFFSET - BALL_SIZE);
    localparam logic [10:0] BALL_W       = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_H        = 11'(PADDLE_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     x_q, x_d;
    logic [9:0]     y_q, y_d;
    logic           dx_q, dx_d;
    logic           dy_q, dy_d;
    logic [3:0]     score_l_q, score_l_d;
    logic [3:0]     score_r_q, score_r_d;
    logic           winner_q, winner_d;
    logic           visible_q, visible_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           start_q;

    logic           start_rise;
    logic [10:0]    x11, y11, pad_l11, pad_r11;
    logic           miss_left, miss_right;
    logic           hit_left, hit_right;
    logic           hit_top, hit_bottom;
    logic           dx_new, dy_new;
    logic [3:0]     score_l_inc, score_r_inc;

    assign start_rise  = start & ~start_q;

    assign x11         = {1'b0, x_q};
    assign y11         = {1'b0, y_q};
    assign pad_l11     = {1'b0, pad_left_position};
    assign pad_r11     = {1'b0, pad_right_position};

    // Collision terms, evaluated against the current position and the paddle
    // positions sampled this cycle.
    assign miss_left   = ~dx_q && (x11 == 11'd0);
    assign miss_right  =  dx_q && (x11 == X_RIGHT_MISS);
    assign hit_left    = ~dx_q && (x11 == X_LEFT_HIT)
                         && ((y11 + BALL_W) > pad_l11) && (y11 < (pad_l11 + PAD_H));
    assign hit_right   =  dx_q && (x11 == X_RIGHT_HIT)
                         && ((y11 + BALL_W) > pad_r11) && (y11 < (pad_r11 + PAD_H));
    assign hit_top     = ~dy_q && (y11 <= Y_TOP);
    assign hit_bottom  =  dy_q && (y11 >= Y_BOTTOM);

    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    // Direction after this frame's reflections; a corner flips both axes.
    always_comb begin
        dx_new = dx_q;
        dy_new = dy_q;
        if (hit_left)   dx_new = 1'b1;
        if (hit_right)  dx_new = 1'b0;
        if (hit_top)    dy_new = 1'b1;
        if (hit_bottom) dy_new = 1'b0;
    end

    // Match sequencing, scoring and ball motion.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                // A frame in the same cycle as the start event is ignored.
                if (start_rise) begin
                    state_d   = ST_SERVE;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    cnt_d     = '0;
                    x_d       = CX;
                    y_d       = CY;
                    dx_d      = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (frame) begin
                    if (miss_left) begin
                        // Right player scores; ball is not moved this frame.
                        score_r_d = score_r_inc;
                        if (score_r_inc == WIN) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d = ST_SERVE;
                            x_d     = CX;
                            y_d     = CY;
                            cnt_d   = '0;
                            dx_d    = 1'b0;
                        end
                    end else if (miss_right) begin
                        score_l_d = score_l_inc;
                        if (score_l_inc == WIN) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b0;
                        end else begin
                            state_d = ST_SERVE;
                            x_d     = CX;
                            y_d     = CY;
                            cnt_d   = '0;
                            dx_d    = 1'b1;
                        end
                    end else begin
                        // The new direction is applied in the same frame.
                        dx_d = dx_new;
                        dy_d = dy_new;
                        x_d  = dx_new ? (x_q + 10'd1) : (x_q - 10'd1);
                        y_d  = dy_new ? (y_q + 10'd1) : (y_q - 10'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        visible_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    end

    // State register; reset wins over every other event.
    always_ff @(posedge clock_25M) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= CX;
            y_q       <= CY;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            winner_q  <= 1'b0;
            visible_q <= 1'b0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            visible_q <= visible_d;
            cnt_q     <= cnt_d;
            start_q   <= start;
        end
    end

    assign ball_x       = x_q;
    assign ball_y       = y_q;
    assign ball_visible = visible_q;
    assign score_left   = score_l_q;
    assign score_right  = score_r_q;
    assign game_state   = state_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller. Stimulus pushes hand-computed
// expected snapshots into a queue; a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_pong_match_controller;

    logic       clock_25M = 1'b0;
    logic       reset = 1'b1;
    logic       frame = 1'b0;
    logic       start = 1'b0;
    logic [9:0] pad_left_position = 10'd0;
    logic [9:0] pad_right_position = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic       ball_visible;
    logic [3:0] score_left, score_right;
    logic [1:0] game_state;
    logic       winner;

    pong_match_controller dut (
        .clock_25M          (clock_25M),
        .reset              (reset),
        .frame              (frame),
        .start              (start),
        .pad_left_position  (pad_left_position),
        .pad_right_position (pad_right_position),
        .ball_x             (ball_x),
        .ball_y             (ball_y),
        .ball_visible       (ball_visible),
        .score_left         (score_left),
        .score_right        (score_right),
        .game_state         (game_state),
        .winner             (winner)
    );

    always #20 clock_25M = ~clock_25M;

    typedef struct {
        logic [8*16-1:0] name;
        logic [1:0]      st;
        logic [9:0]      x;
        logic [9:0]      y;
        logic            care_y;
        logic            vis;
        logic [3:0]      sl;
        logic [3:0]      sr;
        logic            care_w;
        logic            w;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: every pending expectation is checked on the falling edge.
    always @(negedge clock_25M) begin : monitor
        exp_t e;
        logic ok;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (game_state == e.st) && (ball_x == e.x) && (ball_visible == e.vis)
                 && (score_left == e.sl) && (score_right == e.sr)
                 && (!e.care_y || ball_y == e.y) && (!e.care_w || winner == e.w);
            n_cmp = n_cmp + 1;
            if (!ok) begin
                n_bad = n_bad + 1;
                $display("FAIL %0s: got st=%0d x=%0d y=%0d vis=%0d L=%0d R=%0d w=%0d, want st=%0d x=%0d y=%0d%s vis=%0d L=%0d R=%0d w=%0d%s",
                         e.name, game_state, ball_x, ball_y, ball_visible, score_left,
                         score_right, winner, e.st, e.x, e.y, e.care_y ? "" : "(any)",
                         e.vis, e.sl, e.sr, e.w, e.care_w ? "" : "(any)");
            end else begin
                $display("check %0s: st=%0d x=%0d y=%0d L=%0d R=%0d ok",
                         e.name, game_state, ball_x, ball_y, score_left, score_right);
            end
        end
    end

    task automatic tick();
        @(posedge clock_25M);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            tick();
        end
    endtask

    task automatic expect_out(input logic [8*16-1:0] nm, input logic [1:0] st,
                              input logic [9:0] x, input logic [9:0] y, input logic care_y,
                              input logic vis, input logic [3:0] sl, input logic [3:0] sr,
                              input logic care_w, input logic w);
        exp_t e;
        e.name = nm; e.st = st; e.x = x; e.y = y; e.care_y = care_y; e.vis = vis;
        e.sl = sl; e.sr = sr; e.care_w = care_w; e.w = w;
        exp_q.push_back(e);
    endtask

    initial begin : watchdog
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset and idle behaviour.
        reset = 1'b1;
        tick(); tick();
        expect_out("reset", 2'd0, 10'd316, 10'd236, 1, 0, 4'd0, 4'd0, 1, 0);
        reset = 1'b0;
        frames(5);
        expect_out("idle_frames", 2'd0, 10'd316, 10'd236, 1, 0, 4'd0, 4'd0, 1, 0);

        // Start edge together with a frame: the frame must not count.
        pad_left_position  = 10'd150;
        pad_right_position = 10'd380;
        start = 1'b1;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        expect_out("start_serve", 2'd1, 10'd316, 10'd236, 1, 1, 4'd0, 4'd0, 0, 0);
        repeat (9) tick();
        start = 1'b0;
        tick();
        frames(59);
        expect_out("serve_59", 2'd1, 10'd316, 10'd236, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("play_entry", 2'd2, 10'd316, 10'd236, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("play_f1", 2'd2, 10'd317, 10'd237, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(231);
        expect_out("bottom_f232", 2'd2, 10'd548, 10'd468, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("bottom_bounce", 2'd2, 10'd549, 10'd467, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(54);
        expect_out("at_rpad_f287", 2'd2, 10'd603, 10'd413, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("rpad_hit", 2'd2, 10'd602, 10'd412, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(572);
        expect_out("at_lpad_f860", 2'd2, 10'd30, 10'd170, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("lpad_hit", 2'd2, 10'd31, 10'd171, 1, 1, 4'd0, 4'd0, 0, 0);

        // Reset coincident with a frame in PLAY.
        reset = 1'b1;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        expect_out("reset_in_play", 2'd0, 10'd316, 10'd236, 1, 0, 4'd0, 4'd0, 1, 0);
        reset = 1'b0;
        tick();

        // Right player misses until the left player wins.
        pad_right_position = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("start_2", 2'd1, 10'd316, 10'd236, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(60);
        frames(316);
        expect_out("no_hit_f316", 2'd2, 10'd632, 10'd384, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("edge_f317", 2'd2, 10'd633, 10'd383, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("miss_right_1", 2'd1, 10'd316, 10'd236, 1, 1, 4'd1, 4'd0, 0, 0);
        pad_right_position = 10'd1000;
        frames(61);
        expect_out("serve_dir", 2'd2, 10'd317, 10'd235, 1, 1, 4'd1, 4'd0, 0, 0);
        frames(317);
        expect_out("miss_right_2", 2'd1, 10'd316, 10'd236, 1, 1, 4'd2, 4'd0, 0, 0);
        for (int p = 3; p <= 7; p++) begin
            frames(378);
            if (p < 7)
                expect_out("miss_right_n", 2'd1, 10'd316, 10'd236, 1, 1, 4'(p), 4'd0, 0, 0);
            else
                expect_out("left_wins", 2'd3, 10'd633, 10'd0, 0, 0, 4'd7, 4'd0, 1, 0);
        end
        frames(3);
        expect_out("over_hold", 2'd3, 10'd633, 10'd0, 0, 0, 4'd7, 4'd0, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("restart", 2'd1, 10'd316, 10'd236, 1, 1, 4'd0, 4'd0, 0, 0);

        // Left player misses.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pad_left_position  = 10'd1000;
        pad_right_position = 10'd380;
        start = 1'b1;
        tick();
        start = 1'b0;
        frames(60);
        frames(890);
        expect_out("edge_left", 2'd2, 10'd0, 10'd200, 1, 1, 4'd0, 4'd0, 0, 0);
        frames(1);
        expect_out("miss_left", 2'd1, 10'd316, 10'd236, 1, 1, 4'd0, 4'd1, 0, 0);
        frames(61);
        expect_out("serve_dir_l", 2'd2, 10'd315, 10'd237, 1, 1, 4'd0, 4'd1, 0, 0);

        tick(); tick();
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
